// File: rtl/poly_z_pack_pkg.sv
// Shared constants, FSM encoding and field-width helper for the z/y polynomial packer.
// The optional range checker is enabled by defining ZPACK_RANGE_CHECK_EN.
package poly_z_pack_pkg;

    localparam int N_COEFFS        = 256;
    localparam int Q               = 8380417;
    localparam int GAMMA1_BITS_DEF = 19;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PACK,
        DONE
    } zpackState_e;

    // Each packed field carries one extra bit so the whole (-GAMMA1, GAMMA1] span fits.
    function automatic int fieldWidth(input int gamma1Bits);
        return gamma1Bits + 1;
    endfunction

endpackage

// File: rtl/poly_z_pack_if.sv
// Request/result bundle between the coefficient source, the packer and the signature buffer.
// The range_err line only carries information when ZPACK_RANGE_CHECK_EN is defined.
interface poly_z_pack_if
    import poly_z_pack_pkg::*;
#(
    parameter int GAMMA1_BITS = GAMMA1_BITS_DEF
);

    localparam int W = fieldWidth(GAMMA1_BITS);

    logic                      start;
    logic [N_COEFFS*32-1:0]    a_in;
    logic [N_COEFFS*W-1:0]     z_out;
    logic                      busy;
    logic                      done;
    logic                      range_err;

    modport master (
        output start, a_in,
        input  z_out, busy, done, range_err
    );

    modport slave (
        input  start, a_in,
        output z_out, busy, done, range_err
    );

endinterface

// File: rtl/poly_z_pack_lane.sv
// One packing lane: maps a signed coefficient c to (2^GAMMA1_BITS - c) mod 2^W.
// With ZPACK_RANGE_CHECK_EN defined it also flags c outside (-GAMMA1, GAMMA1].
module zpack_lane
    import poly_z_pack_pkg::*;
#(
    parameter int GAMMA1_BITS = GAMMA1_BITS_DEF
) (
    input  logic signed [31:0]                   coeff_i,
`ifdef ZPACK_RANGE_CHECK_EN
    output logic                                 err_o,
`endif
    output logic [fieldWidth(GAMMA1_BITS)-1:0]   t_o
);

    localparam int W = fieldWidth(GAMMA1_BITS);
    localparam logic signed [32:0] GAMMA1 = 33'sd1 <<< GAMMA1_BITS;

    logic signed [32:0] coeffExt;

    assign coeffExt = 33'(coeff_i);

    // Only the low W bits of the 33-bit difference are kept; wrap-around is intended.
    assign t_o = W'(GAMMA1 - coeffExt);

`ifdef ZPACK_RANGE_CHECK_EN
    assign err_o = (coeffExt <= -GAMMA1) || (coeffExt > GAMMA1);
`endif

endmodule

// File: rtl/poly_z_pack.sv
// Packs 256 gamma1-range coefficients into contiguous W-bit fields, LANES per cycle.
// Define ZPACK_RANGE_CHECK_EN to build the sticky out-of-range detector.
module poly_z_pack
    import poly_z_pack_pkg::*;
#(
    parameter int GAMMA1_BITS = GAMMA1_BITS_DEF,
    parameter int LANES       = 4
) (
    input  logic          clock,
    input  logic          reset,
    poly_z_pack_if.slave  bus
);

    localparam int         W        = fieldWidth(GAMMA1_BITS);
    localparam logic [7:0] IDX_STEP = 8'(LANES);
    localparam logic [7:0] LAST_IDX = 8'(N_COEFFS - LANES);

    zpackState_e              stateQ, stateD;
    logic [7:0]               idxQ, idxD;
    logic [N_COEFFS*32-1:0]   bufQ, bufD;
    logic [N_COEFFS*W-1:0]    zQ, zD;
    logic [7:0]               laneIdx [LANES];
    logic [W-1:0]             laneT   [LANES];

`ifdef ZPACK_RANGE_CHECK_EN
    logic                     errQ, errD;
    logic [LANES-1:0]         laneErr;
`endif

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : gLane
            assign laneIdx[k] = idxQ + 8'(k);

            zpack_lane #(
                .GAMMA1_BITS (GAMMA1_BITS)
            ) uLane (
                .coeff_i (bufQ[{laneIdx[k], 5'b00000} +: 32]),
`ifdef ZPACK_RANGE_CHECK_EN
                .err_o   (laneErr[k]),
`endif
                .t_o     (laneT[k])
            );
        end
    endgenerate

    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        bufD   = bufQ;
        zD     = zQ;
`ifdef ZPACK_RANGE_CHECK_EN
        errD   = errQ;
`endif
        case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    stateD = LOAD;
                end
            end
            LOAD: begin
                bufD   = bus.a_in;
                zD     = '0;
                idxD   = '0;
`ifdef ZPACK_RANGE_CHECK_EN
                errD   = 1'b0;
`endif
                stateD = PACK;
            end
            PACK: begin
                for (int i = 0; i < LANES; i++) begin
                    zD[W*int'(laneIdx[i]) +: W] = laneT[i];
                end
                idxD = idxQ + IDX_STEP;
`ifdef ZPACK_RANGE_CHECK_EN
                errD = errQ | (|laneErr);
`endif
                if (idxQ == LAST_IDX) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                // Waiting for start to drop prevents a held request from re-triggering.
                if (!bus.start) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            idxQ   <= '0;
            bufQ   <= '0;
            zQ     <= '0;
`ifdef ZPACK_RANGE_CHECK_EN
            errQ   <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            bufQ   <= bufD;
            zQ     <= zD;
`ifdef ZPACK_RANGE_CHECK_EN
            errQ   <= errD;
`endif
        end
    end

    assign bus.z_out = zQ;
    assign bus.busy  = (stateQ == LOAD) || (stateQ == PACK);
    assign bus.done  = (stateQ == DONE);
`ifdef ZPACK_RANGE_CHECK_EN
    assign bus.range_err = errQ;
`else
    assign bus.range_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_z_pack.sv
// Self-checking bench for poly_z_pack: cycle-level reference model plus literal spot checks.
// Range-error expectations follow ZPACK_RANGE_CHECK_EN when it is defined for the build.
module tb_poly_z_pack;

    localparam int G     = 19;
    localparam int W     = G + 1;
    localparam int NC    = 256;
    localparam int LANES = 4;
    localparam int RUN_CYCLES = 1 + NC / LANES;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   compareOn = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    poly_z_pack_if #(.GAMMA1_BITS(G)) bus ();

    poly_z_pack #(
        .GAMMA1_BITS (G),
        .LANES       (LANES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Field i of the packed string is (2^G - c_i) mod 2^W, computed with plain integers.
    function automatic logic [NC*W-1:0] packModel(input logic [NC*32-1:0] a);
        logic [NC*W-1:0] z;
        longint c, t;
        z = '0;
        for (int i = 0; i < NC; i++) begin
            c = longint'($signed(a[32*i +: 32]));
            t = ((longint'(1) << G) - c) & ((longint'(1) << W) - 1);
            z[W*i +: W] = t[W-1:0];
        end
        return z;
    endfunction

    function automatic logic rangeModel(input logic [NC*32-1:0] a);
        logic bad;
        longint c;
        bad = 1'b0;
`ifdef ZPACK_RANGE_CHECK_EN
        for (int i = 0; i < NC; i++) begin
            c = longint'($signed(a[32*i +: 32]));
            if (c <= -(longint'(1) << G) || c > (longint'(1) << G)) bad = 1'b1;
        end
`else
        c = 0;
        bad = (c != 0) && (a == '0);
`endif
        return bad;
    endfunction

    function automatic logic [NC*32-1:0] fillPoly(input int v);
        logic [NC*32-1:0] a;
        for (int i = 0; i < NC; i++) a[32*i +: 32] = v;
        return a;
    endfunction

    function automatic logic [NC*32-1:0] randPoly(input bit wild);
        logic [NC*32-1:0] a;
        int c;
        for (int i = 0; i < NC; i++) begin
            if (wild && $urandom_range(0, 15) == 0) c = int'($urandom());
            else c = int'($urandom_range(0, 1048575)) - 524287;
            a[32*i +: 32] = c;
        end
        return a;
    endfunction

    // Reference model: 0 idle, 1 running (load + packing), 2 result presented.
    int              mMode = 0;
    int              mCnt  = 0;
    logic [NC*W-1:0] mZ    = '0;
    logic [NC*W-1:0] mPend = '0;
    logic            mErr  = 1'b0;
    logic            mPendErr = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mMode = 0;
            mCnt  = 0;
            mZ    = '0;
            mErr  = 1'b0;
        end else begin
            case (mMode)
                0: if (bus.start) begin
                    mMode = 1;
                    mCnt  = 0;
                end
                1: begin
                    mCnt++;
                    if (mCnt == 1) begin
                        mPend    = packModel(bus.a_in);
                        mPendErr = rangeModel(bus.a_in);
                        mZ       = '0;
                        mErr     = 1'b0;
                    end
                    if (mCnt == RUN_CYCLES) begin
                        mMode = 2;
                        mZ    = mPend;
                        mErr  = mPendErr;
                    end
                end
                default: if (!bus.start) mMode = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWide(input string name, input logic [NC*W-1:0] act, input logic [NC*W-1:0] exp);
        int firstBad;
        checks++;
        if (act !== exp) begin
            fails++;
            firstBad = 0;
            for (int i = NC - 1; i >= 0; i--) begin
                if (act[W*i +: W] !== exp[W*i +: W]) firstBad = i;
            end
            $display("[TB] FAIL %s: field %0d got 0x%0h, expected 0x%0h at %0t",
                     name, firstBad, act[W*firstBad +: W], exp[W*firstBad +: W], $time);
        end
    endtask

    always @(negedge clock) begin
        if (compareOn) begin
            checkOutput("busy", 64'(bus.busy), 64'(mMode == 1));
            checkOutput("done", 64'(bus.done), 64'(mMode == 2));
            if (mMode != 1) begin
                checkWide("z_out", bus.z_out, mZ);
                checkOutput("range_err", 64'(bus.range_err), 64'(mErr));
            end
        end
    end

    // Requests a run with coefficients a, scrambles a_in after the capture edge, waits for done.
    task automatic applyStimulus(input logic [NC*32-1:0] a);
        int lat;
        @(negedge clock);
        bus.a_in  = a;
        bus.start = 1'b1;
        @(posedge clock);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) bus.a_in = randPoly(1'b1);
        end while (!bus.done && lat < 200);
        checkOutput("latency", 64'(lat), 64'(RUN_CYCLES));
        checkWide("packed", bus.z_out, packModel(a));
        checkOutput("run_err", 64'(bus.range_err), 64'(rangeModel(a)));
    endtask

    task automatic dropStart();
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("done_fall", 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [NC*32-1:0] a;
        bus.start = 1'b0;
        bus.a_in  = '0;
        #3 reset = 1'b0;
        compareOn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_err", 64'(bus.range_err), 64'd0);
        checkWide("rst_z", bus.z_out, '0);
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] all-zero coefficients");
        applyStimulus(fillPoly(0));
        checkOutput("zero_b0", 64'(bus.z_out[7:0]), 64'h00);
        checkOutput("zero_b1", 64'(bus.z_out[15:8]), 64'h00);
        checkOutput("zero_b2", 64'(bus.z_out[23:16]), 64'h08);
        checkOutput("zero_b3", 64'(bus.z_out[31:24]), 64'h00);
        checkOutput("zero_b4", 64'(bus.z_out[39:32]), 64'h80);
        checkOutput("zero_f255", 64'(bus.z_out[W*255 +: W]), 64'h80000);
        dropStart();

        $display("[TB] all coefficients at GAMMA1");
        applyStimulus(fillPoly(524288));
        checkWide("gamma1_zero", bus.z_out, '0);
        checkOutput("gamma1_err", 64'(bus.range_err), 64'd0);
        dropStart();

        $display("[TB] all coefficients at -GAMMA1+1");
        applyStimulus(fillPoly(-524287));
        checkWide("all_ff", bus.z_out, {(NC*W){1'b1}});
        dropStart();

        $display("[TB] ramp coefficients");
        for (int i = 0; i < NC; i++) a[32*i +: 32] = i;
        applyStimulus(a);
        checkOutput("ramp_f0", 64'(bus.z_out[0 +: W]), 64'h80000);
        checkOutput("ramp_f1", 64'(bus.z_out[W +: W]), 64'h7FFFF);
        checkOutput("ramp_f255", 64'(bus.z_out[W*255 +: W]), 64'h7FF01);
        dropStart();

        $display("[TB] coefficient 7 at -GAMMA1, then start held high");
        a = fillPoly(0);
        a[32*7 +: 32] = -524288;
        applyStimulus(a);
        checkOutput("c7_field", 64'(bus.z_out[W*7 +: W]), 64'h00000);
`ifdef ZPACK_RANGE_CHECK_EN
        checkOutput("c7_err", 64'(bus.range_err), 64'd1);
`else
        checkOutput("c7_err", 64'(bus.range_err), 64'd0);
`endif
        repeat (10) @(posedge clock);
        #1;
        checkOutput("hold_done", 64'(bus.done), 64'd1);
        checkOutput("hold_busy", 64'(bus.busy), 64'd0);
        dropStart();
        applyStimulus(randPoly(1'b0));
        dropStart();

        $display("[TB] reset during packing");
        @(negedge clock);
        bus.a_in  = randPoly(1'b0);
        bus.start = 1'b1;
        @(posedge clock);
        repeat (31) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkWide("abort_z", bus.z_out, '0);
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(randPoly(r[0]));
            dropStart();
        end

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
